// File: rtl/ctrl_sumres4_pkg.sv
// Shared state encoding, opcode and mode constants for the ctrl_sumres4 add/subtract engine.
// Also holds the registered result bundle type and the signed-overflow helper.
package ctrl_sumres4_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CPL  = 3'd1;
    localparam logic [2:0] SUM  = 3'd2;
    localparam logic [2:0] EAC  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MODE_TWOS = 0;
    localparam int MODE_ONES = 1;

    typedef struct packed {
        logic [3:0] result;
        logic       cout;
        logic       ovf;
        logic       zero;
    } res_t;

    // Same-sign operands producing a differently-signed result means overflow.
    function automatic logic ovf_calc(input logic [3:0] a, input logic [3:0] bc, input logic [3:0] s);
        return (a[3] == bc[3]) && (s[3] != a[3]);
    endfunction

endpackage

// File: rtl/ctrl_sumres4_if.sv
// Request/response bundle between the front end (master) and the ctrl_sumres4 engine (slave).
// Request side is valid/ready, response side is valid/ready with result and flags.
interface ctrl_sumres4_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/ctrl_sumres4_compl1.sv
// compl1: 4-bit conditional ones' complement, Outp = cpl ? ~Inp : Inp.
// Latency: combinational. Backpressure: none.
// Pure datapath cell; the surrounding controller sequences it.
module compl1 (
    input  logic [3:0] Inp,
    input  logic       cpl,
    output logic [3:0] Outp
);
    assign Outp = cpl ? ~Inp : Inp;
endmodule

// File: rtl/ctrl_sumres4.sv
// Handshaked 4-bit add/subtract engine built around compl1 and an inline adder.
// Latency: out_valid 3 edges after accept (4 when end-around carry is taken); one op per >=4 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
module ctrl_sumres4
    import ctrl_sumres4_pkg::*;
#(
    parameter int ONES = MODE_TWOS
) (
    input  logic           clk,
    input  logic           reset_n,
    ctrl_sumres4_if.slave  bus,
    output logic           busy,
    output logic [7:0]     ops_count
);

    localparam logic ONES_MODE = (ONES != MODE_TWOS);

    logic [2:0] state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [3:0] bc;
    logic       op_reg;
    logic [3:0] cpl_out;
    logic [4:0] sum5;
    logic [3:0] inc;
    logic       cin;
    res_t       res_q;

    compl1 u_compl1 (
        .Inp  (b_reg),
        .cpl  (op_reg),
        .Outp (cpl_out)
    );

    // Two's complement folds the +1 of negation into carry-in; ones' mode uses end-around carry instead.
    assign cin  = ONES_MODE ? 1'b0 : (op_reg == OP_SUB);
    assign sum5 = {1'b0, a_reg} + {1'b0, bc} + {4'b0000, cin};
    assign inc  = res_q.result + 4'd1;

    function automatic logic is_zero(input logic [3:0] r);
        return (r == 4'b0000) || (ONES_MODE && (r == 4'b1111));
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            bc        <= '0;
            op_reg    <= 1'b0;
            res_q     <= '0;
            ops_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        op_reg <= bus.op;
                        state  <= CPL;
                    end
                end
                CPL: begin
                    bc    <= cpl_out;
                    state <= SUM;
                end
                SUM: begin
                    res_q.result <= sum5[3:0];
                    res_q.cout   <= sum5[4];
                    res_q.ovf    <= ovf_calc(a_reg, bc, sum5[3:0]);
                    res_q.zero   <= is_zero(sum5[3:0]);
                    state        <= (ONES_MODE && sum5[4]) ? EAC : DONE;
                end
                EAC: begin
                    res_q.result <= inc;
                    res_q.ovf    <= ovf_calc(a_reg, bc, inc);
                    res_q.zero   <= is_zero(inc);
                    state        <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        if (ops_count != 8'hFF) begin
                            ops_count <= ops_count + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q.result;
    assign bus.cout      = res_q.cout;
    assign bus.ovf       = res_q.ovf;
    assign bus.zero      = res_q.zero;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ctrl_sumres4.sv
// Bench for ctrl_sumres4: one instance per arithmetic mode, random and directed ops
// compared against an integer-arithmetic reference model.
module tb_ctrl_sumres4;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic [2:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       iv[2];
    logic       ordy[2];
    logic [3:0] da[2];
    logic [3:0] db[2];
    logic       dop[2];
    logic       ir[2];
    logic       ov[2];
    logic [3:0] rs[2];
    logic       co[2];
    logic       vf[2];
    logic       zr[2];
    logic       bz[2];
    logic [7:0] cn[2];

    int nchk = 0;
    int nerr = 0;
    int ecnt[2];

    ctrl_sumres4_if if0 ();
    ctrl_sumres4_if if1 ();

    assign if0.in_valid = iv[0];
    assign if0.a        = da[0];
    assign if0.b        = db[0];
    assign if0.op       = dop[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];
    assign if1.a        = da[1];
    assign if1.b        = db[1];
    assign if1.op       = dop[1];
    assign if1.out_ready = ordy[1];

    assign ir[0] = if0.in_ready;
    assign ov[0] = if0.out_valid;
    assign rs[0] = if0.result;
    assign co[0] = if0.cout;
    assign vf[0] = if0.ovf;
    assign zr[0] = if0.zero;
    assign ir[1] = if1.in_ready;
    assign ov[1] = if1.out_valid;
    assign rs[1] = if1.result;
    assign co[1] = if1.cout;
    assign vf[1] = if1.ovf;
    assign zr[1] = if1.zero;

    ctrl_sumres4 #(.ONES(0)) u_twos (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (if0),
        .busy      (bz[0]),
        .ops_count (cn[0])
    );

    ctrl_sumres4 #(.ONES(1)) u_ones (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (if1),
        .busy      (bz[1]),
        .ops_count (cn[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic on the operand values, not bit-level datapath.
    function automatic exp_t model(input int m, input logic [3:0] a, input logic [3:0] b, input logic op);
        exp_t e;
        int ai = int'(a);
        int bi = int'(b);
        int sa, sb, sv, sum, raw;
        if (m == 0) begin
            sa = (ai >= 8) ? ai - 16 : ai;
            sb = (bi >= 8) ? bi - 16 : bi;
            if (op) begin
                sum = ai - bi;
                e.c = (ai >= bi);
                sv  = sa - sb;
            end else begin
                sum = ai + bi;
                e.c = (sum > 15);
                sv  = sa + sb;
            end
            e.res = 4'(sum & 15);
            e.v   = (sv > 7) || (sv < -8);
            e.z   = (e.res == 4'd0);
            e.lat = 3'd3;
        end else begin
            sa  = (ai >= 8) ? ai - 15 : ai;
            sb  = (bi >= 8) ? bi - 15 : bi;
            sv  = op ? sa - sb : sa + sb;
            raw = ai + (op ? 15 - bi : bi);
            e.c   = (raw > 15);
            e.res = 4'((raw > 15) ? raw - 15 : raw);
            e.v   = (sv > 7) || (sv < -7);
            e.z   = (e.res == 4'd0) || (e.res == 4'd15);
            e.lat = (raw > 15) ? 3'd4 : 3'd3;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input logic [3:0] a, input logic [3:0] b, input logic op);
        int t = 0;
        while (ir[m] !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("issue_ready", {31'd0, ir[m]}, 32'd1);
        iv[m]  = 1'b1;
        da[m]  = a;
        db[m]  = b;
        dop[m] = op;
        step();
        iv[m]  = 1'b0;
        da[m]  = 4'($urandom);
        db[m]  = 4'($urandom);
        dop[m] = 1'($urandom);
        chk("accept_busy", {31'd0, bz[m]}, 32'd1);
    endtask

    task automatic wait_done(input int m, input exp_t e);
        int lat = 1;
        while (ov[m] !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        chk("latency", lat, {29'd0, e.lat});
        chk("result", {28'd0, rs[m]}, {28'd0, e.res});
        chk("cout", {31'd0, co[m]}, {31'd0, e.c});
        chk("ovf", {31'd0, vf[m]}, {31'd0, e.v});
        chk("zero", {31'd0, zr[m]}, {31'd0, e.z});
        chk("done_ready", {31'd0, ir[m]}, 32'd0);
    endtask

    task automatic retire(input int m, input int hold, input exp_t e);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_valid", {31'd0, ov[m]}, 32'd1);
            chk("hold_result", {28'd0, rs[m]}, {28'd0, e.res});
            chk("hold_ready", {31'd0, ir[m]}, 32'd0);
        end
        ordy[m] = 1'b1;
        step();
        ordy[m] = 1'b0;
        if (ecnt[m] < 255) ecnt[m]++;
        chk("drain_valid", {31'd0, ov[m]}, 32'd0);
        chk("drain_ready", {31'd0, ir[m]}, 32'd1);
        chk("ops_count", {24'd0, cn[m]}, ecnt[m]);
    endtask

    task automatic run_op(input int m, input logic [3:0] a, input logic [3:0] b, input logic op, input int hold);
        exp_t e;
        e = model(m, a, b, op);
        issue(m, a, b, op);
        wait_done(m, e);
        retire(m, hold, e);
    endtask

    initial begin
        exp_t e1, e2;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; da[i] = '0; db[i] = '0; dop[i] = 1'b0; ecnt[i] = 0;
        end
        reset_n = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'd0, ir[i]}, 32'd1);
            chk("rst_valid", {31'd0, ov[i]}, 32'd0);
            chk("rst_busy", {31'd0, bz[i]}, 32'd0);
            chk("rst_count", {24'd0, cn[i]}, 32'd0);
            chk("rst_flags", {27'd0, rs[i], co[i]}, 32'd0);
            chk("rst_ovfzero", {30'd0, vf[i], zr[i]}, 32'd0);
        end
        reset_n = 1'b1;
        step();

        // Directed cases with literal expectations.
        run_op(0, 4'd5, 4'd3, 1'b1, 0);
        chk("tp1_result", {28'd0, rs[0]}, 32'h2);
        chk("tp1_count", {24'd0, cn[0]}, 32'd1);
        run_op(0, 4'd7, 4'd1, 1'b0, 1);
        chk("tp2_result", {28'd0, rs[0]}, 32'h8);
        e1 = model(1, 4'b0101, 4'b0011, 1'b1);
        chk("tp3_model_eac", {29'd0, e1.lat}, 32'd4);
        issue(1, 4'b0101, 4'b0011, 1'b1);
        wait_done(1, e1);
        chk("tp3_result", {28'd0, rs[1]}, 32'h2);
        chk("tp3_cout", {31'd0, co[1]}, 32'd1);
        retire(1, 0, e1);
        issue(1, 4'b0011, 4'b0011, 1'b1);
        wait_done(1, model(1, 4'b0011, 4'b0011, 1'b1));
        chk("tp4_result", {28'd0, rs[1]}, 32'hF);
        chk("tp4_zero", {31'd0, zr[1]}, 32'd1);
        retire(1, 0, model(1, 4'b0011, 4'b0011, 1'b1));

        // Backpressure with a second request held on in_valid.
        e1 = model(0, 4'd4, 4'd9, 1'b0);
        e2 = model(0, 4'd12, 4'd3, 1'b1);
        issue(0, 4'd4, 4'd9, 1'b0);
        wait_done(0, e1);
        iv[0] = 1'b1; da[0] = 4'd12; db[0] = 4'd3; dop[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", {31'd0, ov[0]}, 32'd1);
            chk("bp_result", {28'd0, rs[0]}, {28'd0, e1.res});
            chk("bp_flags", {29'd0, co[0], vf[0], zr[0]}, {29'd0, e1.c, e1.v, e1.z});
            chk("bp_ready", {31'd0, ir[0]}, 32'd0);
        end
        ordy[0] = 1'b1;
        step();
        ordy[0] = 1'b0;
        ecnt[0]++;
        chk("bp_hs_valid", {31'd0, ov[0]}, 32'd0);
        chk("bp_hs_busy", {31'd0, bz[0]}, 32'd0);
        chk("bp_hs_count", {24'd0, cn[0]}, ecnt[0]);
        step();
        chk("bp_accept_busy", {31'd0, bz[0]}, 32'd1);
        chk("bp_accept_ready", {31'd0, ir[0]}, 32'd0);
        iv[0] = 1'b0;
        wait_done(0, e2);
        retire(0, 0, e2);

        // Random ops on both modes; enough to drive ops_count into saturation.
        for (int i = 0; i < 540; i++) begin
            run_op(i % 2, 4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        chk("sat_count0", {24'd0, cn[0]}, 32'd255);
        chk("sat_count1", {24'd0, cn[1]}, 32'd255);

        // Reset while the engine sits in SUM.
        issue(0, 4'd9, 4'd6, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ov[0]}, 32'd0);
        chk("mid_rst_ready", {31'd0, ir[0]}, 32'd1);
        chk("mid_rst_busy", {31'd0, bz[0]}, 32'd0);
        chk("mid_rst_count", {24'd0, cn[0]}, 32'd0);
        ecnt[0] = 0;
        ecnt[1] = 0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_valid", {31'd0, ov[0]}, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            run_op(i % 2, 4'($urandom), 4'($urandom), 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ctrl_sumres4.md
Name: ctrl_sumres4

Overview:
Sequencing controller for the 4-bit ones'-complement unit `compl1`. It turns `compl1` plus an inline 4-bit adder into a handshaked add/subtract engine. Each operation is accepted over a valid/ready interface and walked through complement, sum and optional end-around-carry steps. The block sits between a test/control front end and the result register bank, and returns the result with carry, overflow and zero flags.

Parameters:
ONES, 0, arithmetic mode: 0 = two's complement (carry-in = op); 1 = ones' complement (carry-in 0, end-around carry).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request
a  input  4  first operand
b  input  4  second operand
op  input  1  0 = add, 1 = subtract
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  4  sum/difference
cout  output  1  carry out of the SUM step
ovf  output  1  signed overflow
zero  output  1  result is zero
busy  output  1  state != IDLE
ops_count  output  8  completed operations, saturating at 255

Behaviour:
- Interface decision (already fixed): one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset (async, reset_n=0):
  - state=IDLE; result, cout, ovf, zero, out_valid, busy, ops_count = 0.
  - Internal a_reg/b_reg/bc/op_reg = 0.
  - in_ready=1, since in_ready = (state==IDLE).
- States: IDLE, CPL, SUM, EAC, DONE.
- IDLE: if in_valid && in_ready, latch a, b, op into a_reg, b_reg, op_reg and go to CPL. Otherwise stay.
- CPL:
  - Drive the `compl1` instance with Inp=b_reg, cpl=op_reg.
  - Register its output into bc.
  - Go to SUM.
- SUM:
  - {c,s} = a_reg + bc + (ONES ? 0 : op_reg), 5-bit sum.
  - Register result=s and cout=c.
  - ovf = (a_reg[3]==bc[3]) && (s[3]!=a_reg[3]).
  - If ONES==1 && c==1, go to EAC; else go to DONE.
- EAC (ONES==1 only):
  - result = result+1, mod 16; cout stays 1.
  - ovf recomputed with the same formula using the new result.
  - Go to DONE.
- zero flag:
  - zero = (final result==4'b0000).
  - When ONES==1, zero is also set for 4'b1111 (negative zero).
  - zero is registered together with the final result.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_valid && out_ready: go to IDLE and increment ops_count (saturate at 255).
  - No same-cycle accept of a new request.
- Latency, counting the accept edge as edge 1:
  - out_valid is high after edge 3.
  - When the EAC step is taken, out_valid is high after edge 4.
  - Minimum throughput is one operation per 4 cycles.
- Hold rules:
  - in_valid while busy is ignored; the requester must hold it.
  - a, b and op may change after acceptance without effect.
- out_valid stays high indefinitely while out_ready=0.
- busy = (state != IDLE).
- ovf and cout are meaningful only while out_valid=1; they keep their last value otherwise.
- Reset asserted mid-operation:
  - Immediate abort to IDLE; the result is discarded and out_valid=0.
  - ops_count clears.
- Unused state encodings go to IDLE on the next edge.

Decomposition:
- Shared package/header ctrl_sumres4_pkg:
  - State encoding constants: IDLE, CPL, SUM, EAC, DONE (3 bits).
  - OP_ADD=0, OP_SUB=1.
  - ONES mode constants.
- Exactly one sub-module: an instance of the existing `compl1`.
- The adder, flag logic and counter stay inline in ctrl_sumres4.

Test Plan:
- ONES=0, a=4'd5, b=4'd3, op=1, out_ready=1 → result=4'b0010, cout=1, ovf=0, zero=0; out_valid after edge 3; ops_count=1.
- ONES=0, a=4'd7, b=4'd1, op=0 → result=4'b1000, cout=0, ovf=1, zero=0.
- ONES=1, a=4'b0101, b=4'b0011, op=1 → SUM gives 0001 with carry, EAC taken → result=4'b0010, cout=1; out_valid after edge 4.
- ONES=1, a=4'b0011, b=4'b0011, op=1 → result=4'b1111, cout=0, no EAC, zero=1.
- Backpressure: out_ready=0 for 5 cycles, second request held on in_valid=1 with new operands.
  - Result and flags stay stable; in_ready=0.
  - The second request is accepted only in the cycle after the out_valid&&out_ready handshake.
- Reset mid-op: reset_n=0 during SUM → out_valid=0, in_ready=1, busy=0, ops_count=0 immediately; no stale result after release.
